// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC array sequencer.
// Holds the FSM state encoding and the index/shift widths.
// Imported by the counter and the sequencer top.
package mac_pkg;

  localparam int IDX_W         = 4;
  localparam int SHAMT_W       = 5;
  localparam int DRAIN_CYC_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_ILOAD,
    ST_DRAIN,
    ST_OUT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mac_idx_cnt.sv
// Phase index counter: clear, enable, saturating at the limit with a match flag.
// Latency: count visible the cycle after an enabled beat; match flag is combinational.
// No backpressure of its own; the caller gates the enable with memory ready.
module mac_idx_cnt
  import mac_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [IDX_W-1:0] limit_i,
  output logic [IDX_W-1:0] cnt_o,
  output logic             at_limit_o
);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  assign at_limit_o = (cnt_q == limit_i);
  assign cnt_o      = cnt_q;

  // Next count: clear wins, otherwise step on an enabled beat but never past the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a MAC array job: weight load, input load, drain, result output.
// Latency: (K+1)+(N+1)+DRAIN_CYC+(M+1) busy cycles, then a one-cycle DONE.
// Memory not ready stalls the load/output phases indefinitely; drain ignores it.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               ABORT,
  input  logic               MEM_RDY,
  input  logic [IDX_W-1:0]   CFG_K,
  input  logic [IDX_W-1:0]   CFG_N,
  input  logic [IDX_W-1:0]   CFG_M,
  input  logic [SHAMT_W-1:0] CFG_SHAMT,
  output logic               BUSY,
  output logic               DONE,
  output logic               WLoad,
  output logic               ILoad,
  output logic               START_CALC,
  output logic               OVALID,
  output logic [IDX_W-1:0]   WROW,
  output logic [IDX_W-1:0]   ICOL,
  output logic [IDX_W-1:0]   ODST,
  output logic [SHAMT_W-1:0] shamt
);

  state_t             state_q;
  logic [IDX_W-1:0]   cfg_k_q;
  logic [IDX_W-1:0]   cfg_n_q;
  logic [IDX_W-1:0]   cfg_m_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [4:0]         drain_q;

  logic             start_acc;
  logic             w_beat;
  logic             i_beat;
  logic             o_beat;
  logic [IDX_W-1:0] wrow_cnt;
  logic [IDX_W-1:0] icol_cnt;
  logic [IDX_W-1:0] odst_cnt;
  logic             w_last;
  logic             i_last;
  logic             o_last;
  logic             drain_last;

  assign start_acc  = (state_q == ST_IDLE) && START;
  assign w_beat     = (state_q == ST_WLOAD) && MEM_RDY;
  assign i_beat     = (state_q == ST_ILOAD) && MEM_RDY;
  assign o_beat     = (state_q == ST_OUT)   && MEM_RDY;
  assign drain_last = (drain_q == 5'(DRAIN_CYC - 1));

  // All three index counters restart together when a job is accepted.
  mac_idx_cnt u_wrow_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (start_acc),
    .en_i       (w_beat),
    .limit_i    (cfg_k_q),
    .cnt_o      (wrow_cnt),
    .at_limit_o (w_last)
  );

  mac_idx_cnt u_icol_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (start_acc),
    .en_i       (i_beat),
    .limit_i    (cfg_n_q),
    .cnt_o      (icol_cnt),
    .at_limit_o (i_last)
  );

  mac_idx_cnt u_odst_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (start_acc),
    .en_i       (o_beat),
    .limit_i    (cfg_m_q),
    .cnt_o      (odst_cnt),
    .at_limit_o (o_last)
  );

  // Phase FSM, latched job config and drain timer; abort beats any phase transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cfg_k_q <= '0;
      cfg_n_q <= '0;
      cfg_m_q <= '0;
      shamt_q <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            cfg_k_q <= CFG_K;
            cfg_n_q <= CFG_N;
            cfg_m_q <= CFG_M;
            shamt_q <= CFG_SHAMT;
            drain_q <= '0;
            state_q <= ST_WLOAD;
          end
        end
        ST_WLOAD: begin
          if (ABORT) begin
            state_q <= ST_IDLE;
          end else if (w_beat && w_last) begin
            state_q <= ST_ILOAD;
          end
        end
        ST_ILOAD: begin
          if (ABORT) begin
            state_q <= ST_IDLE;
          end else if (i_beat && i_last) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (ABORT) begin
            state_q <= ST_IDLE;
          end else if (drain_last) begin
            drain_q <= '0;
            state_q <= ST_OUT;
          end else begin
            drain_q <= drain_q + 5'd1;
          end
        end
        ST_OUT: begin
          if (ABORT) begin
            state_q <= ST_IDLE;
          end else if (o_beat && o_last) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobe and index decode from registered state; everything reads 0 while reset is held.
  always_comb begin
    BUSY       = 1'b0;
    DONE       = 1'b0;
    WLoad      = 1'b0;
    ILoad      = 1'b0;
    START_CALC = 1'b0;
    OVALID     = 1'b0;
    WROW       = '0;
    ICOL       = '0;
    ODST       = '0;
    shamt      = '0;
    if (!RST) begin
      BUSY       = (state_q == ST_WLOAD) || (state_q == ST_ILOAD) ||
                   (state_q == ST_DRAIN) || (state_q == ST_OUT);
      DONE       = (state_q == ST_DONE);
      WLoad      = w_beat;
      ILoad      = i_beat;
      START_CALC = i_beat && (icol_cnt == '0);
      OVALID     = o_beat;
      WROW       = (state_q == ST_WLOAD) ? wrow_cnt : '0;
      ICOL       = (state_q == ST_ILOAD) ? icol_cnt : '0;
      ODST       = (state_q == ST_OUT)   ? odst_cnt : '0;
      shamt      = shamt_q;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with DRAIN_CYC=3.
// Directed jobs push their hand-derived beat sequence; a negedge monitor pops on every strobe.
// Latency and busy-cycle totals are checked against closed-form values per job.
module tb_mac_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       ABORT;
  logic       MEM_RDY;
  logic [3:0] CFG_K;
  logic [3:0] CFG_N;
  logic [3:0] CFG_M;
  logic [4:0] CFG_SHAMT;
  logic       BUSY;
  logic       DONE;
  logic       WLoad;
  logic       ILoad;
  logic       START_CALC;
  logic       OVALID;
  logic [3:0] WROW;
  logic [3:0] ICOL;
  logic [3:0] ODST;
  logic [4:0] shamt;

  mac_seq_ctrl #(.DRAIN_CYC(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .ABORT      (ABORT),
    .MEM_RDY    (MEM_RDY),
    .CFG_K      (CFG_K),
    .CFG_N      (CFG_N),
    .CFG_M      (CFG_M),
    .CFG_SHAMT  (CFG_SHAMT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .WLoad      (WLoad),
    .ILoad      (ILoad),
    .START_CALC (START_CALC),
    .OVALID     (OVALID),
    .WROW       (WROW),
    .ICOL       (ICOL),
    .ODST       (ODST),
    .shamt      (shamt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] idx;
    logic       calc;
    logic [4:0] sh;
  } ev_t;

  localparam logic [1:0] EV_W = 2'd0;
  localparam logic [1:0] EV_I = 2'd1;
  localparam logic [1:0] EV_O = 2'd2;
  localparam logic [1:0] EV_D = 2'd3;

  ev_t exp_q[$];
  int  checks    = 0;
  int  errors    = 0;
  int  cyc       = 0;
  int  busy_cnt  = 0;
  int  done_cnt  = 0;
  int  done_cyc  = 0;
  int  done_prev = 0;
  int  st_cyc    = 0;

  always @(posedge CLK) cyc++;

  // Monitor: every strobe cycle must match the head of the expected queue.
  always @(negedge CLK) begin
    ev_t act;
    ev_t e;
    int  nstb;
    if (BUSY) busy_cnt++;
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    nstb = int'(WLoad) + int'(ILoad) + int'(OVALID) + int'(DONE);
    if (nstb > 1) begin
      checks++;
      errors++;
      $display("FAIL multi_strobe: %0d strobes at cycle %0d, required at most 1", nstb, cyc);
    end else if (nstb == 1) begin
      act.calc = START_CALC;
      act.sh   = shamt;
      if (WLoad)       begin act.kind = EV_W; act.idx = WROW; end
      else if (ILoad)  begin act.kind = EV_I; act.idx = ICOL; end
      else if (OVALID) begin act.kind = EV_O; act.idx = ODST; end
      else             begin act.kind = EV_D; act.idx = 4'd0; end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got kind=%0d idx=%0d calc=%0b sh=%0d at cycle %0d, required no beat",
                 act.kind, act.idx, act.calc, act.sh, cyc);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL beat: got kind=%0d idx=%0d calc=%0b sh=%0d at cycle %0d, required kind=%0d idx=%0d calc=%0b sh=%0d",
                   act.kind, act.idx, act.calc, act.sh, cyc, e.kind, e.idx, e.calc, e.sh);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic push(input logic [1:0] k, input int idx, input logic calc, input int sh);
    ev_t e;
    e.kind = k;
    e.idx  = 4'(idx);
    e.calc = calc;
    e.sh   = 5'(sh);
    exp_q.push_back(e);
  endtask

  task automatic push_job(input int k, input int n, input int m, input int sh);
    for (int i = 0; i <= k; i++) push(EV_W, i, 1'b0, sh);
    for (int i = 0; i <= n; i++) push(EV_I, i, (i == 0), sh);
    for (int i = 0; i <= m; i++) push(EV_O, i, 1'b0, sh);
    push(EV_D, 0, 1'b0, sh);
  endtask

  // Drives START for the current cycle (cycle 0 of the job) and leaves the bench in cycle 1.
  task automatic start_job(input int k, input int n, input int m, input int sh);
    CFG_K     = 4'(k);
    CFG_N     = 4'(n);
    CFG_M     = 4'(m);
    CFG_SHAMT = 5'(sh);
    START     = 1'b1;
    st_cyc    = cyc;
    busy_cnt  = 0;
    done_prev = done_cnt;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input int lat, input int bexp);
    int t = 0;
    while (done_cnt == done_prev && t < 400) begin
      tick();
      t++;
    end
    if (done_cnt == done_prev) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE in 400 cycles, required DONE at cycle %0d", lat);
    end else begin
      chk("done_latency", done_cyc - st_cyc, lat);
      chk("busy_cycles", busy_cnt, bexp);
    end
    tick();
    chk("idle_after_done", int'(BUSY), 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, int'({BUSY, DONE, WLoad, ILoad, START_CALC, OVALID, WROW, ICOL, ODST, shamt}), 0);
  endtask

  initial begin
    RST       = 1'b1;
    START     = 1'b1;
    ABORT     = 1'b0;
    MEM_RDY   = 1'b1;
    CFG_K     = 4'd5;
    CFG_N     = 4'd5;
    CFG_M     = 4'd5;
    CFG_SHAMT = 5'd17;

    // Reset holds everything at 0 even with START asserted.
    tick();
    tick();
    @(negedge CLK);
    chk_all_zero("reset_outputs");
    tick();
    START = 1'b0;
    RST   = 1'b0;
    tick();
    chk_all_zero("post_reset_idle");

    // K=1,N=0,M=0: W0 W1, I0+calc, 3 drain, O0, DONE at cycle 8, 7 busy cycles.
    push_job(1, 0, 0, 5);
    start_job(1, 0, 0, 5);
    wait_done(8, 7);
    chk("shamt_held_idle", int'(shamt), 5);

    // K=3 with memory stalled in cycles 2-4: WROW frozen at 1, 12 busy cycles.
    push_job(3, 0, 0, 2);
    start_job(3, 0, 0, 2);
    tick();
    MEM_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_wrow", int'(WROW), 1);
      chk("stall_wload", int'(WLoad), 0);
      chk("stall_busy", int'(BUSY), 1);
      tick();
    end
    MEM_RDY = 1'b1;
    wait_done(13, 12);

    // Full-size job: 16 beats per phase, no wrap, 51 busy cycles.
    push_job(15, 15, 15, 31);
    start_job(15, 15, 15, 31);
    wait_done(52, 51);

    // Abort on the ICOL=2 beat, then an immediate new job.
    push(EV_W, 0, 1'b0, 3);
    push(EV_I, 0, 1'b1, 3);
    push(EV_I, 1, 1'b0, 3);
    push(EV_I, 2, 1'b0, 3);
    start_job(0, 5, 0, 3);
    tick();
    tick();
    tick();
    ABORT = 1'b1;
    @(negedge CLK);
    chk("abort_beat_icol", int'(ICOL), 2);
    tick();
    ABORT = 1'b0;
    chk("abort_idle_busy", int'(BUSY), 0);
    chk("abort_no_done", done_cnt, done_prev);
    chk("abort_queue", exp_q.size(), 0);
    push_job(0, 0, 0, 4);
    start_job(0, 0, 0, 4);
    wait_done(7, 6);

    // START while busy is ignored; reset during drain clears everything with no DONE.
    for (int i = 0; i <= 2; i++) push(EV_W, i, 1'b0, 7);
    for (int i = 0; i <= 2; i++) push(EV_I, i, (i == 0), 7);
    start_job(2, 2, 2, 7);
    START     = 1'b1;
    CFG_K     = 4'd0;
    CFG_M     = 4'd0;
    CFG_SHAMT = 5'd9;
    tick();
    START = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("drain_busy", int'(BUSY), 1);
    chk("drain_shamt", int'(shamt), 7);
    chk("drain_queue", exp_q.size(), 0);
    RST = 1'b1;
    @(negedge CLK);
    chk_all_zero("reset_in_drain");
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk_all_zero("after_drain_reset");
    for (int i = 0; i < 10; i++) tick();
    chk("no_done_after_reset", done_cnt, done_prev);
    chk("still_idle", int'(BUSY), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
